// File: rtl/sysarr_row_loader_if.sv
// rtl/sysarr_row_loader_if.sv - scratchpad read port: pipelined in-order request/response
interface sysarr_row_loader_if #(
    parameter int AW = 32,
    parameter int N  = 4,
    parameter int DW = 16
) ();
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_rsp_valid;
    logic [N*DW-1:0]   mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/sysarr_row_loader.sv
// rtl/sysarr_row_loader.sv - GEMM row sequencer: scratchpad reads to systolic array row strobes
// Optional stall counter output perf_stall_cycles under `define SYSARR_ROW_LOADER_PERF_EN.
module sysarr_row_loader #(
    parameter int N          = 4,
    parameter int DW         = 16,
    parameter int AW         = 32,
    parameter int ROW_STRIDE = 64,
    parameter int MAX_OUT    = 4,
    localparam int RW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load_w,
    input  logic [AW-1:0]     req_w_addr,
    input  logic [AW-1:0]     req_in_addr,
    input  logic [AW-1:0]     req_ps_addr,
    sysarr_row_loader_if.master mem,
    input  logic              fifo_has_space,
    output logic              weight_en,
    output logic              input_en,
    output logic              partial_en,
    output logic [RW-1:0]     row_in_en,
    output logic [RW-1:0]     row_ps_en,
    output logic [N*DW-1:0]   row_data,
    output logic              busy,
    output logic              err_rsp
`ifdef SYSARR_ROW_LOADER_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles
`endif
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int TW = RW + 2;

    localparam logic [1:0] TY_W  = 2'd0;
    localparam logic [1:0] TY_IN = 2'd1;
    localparam logic [1:0] TY_PS = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_W, S_ISSUE_W, S_WAIT_SPACE, S_ISSUE_IN, S_ISSUE_PS, S_DRAIN
    } state_t;

    state_t          r_state, w_next;
    logic            r_load_w;
    logic [AW-1:0]   r_w_base, r_in_base, r_ps_base;
    logic [RW-1:0]   r_row;
    logic [TW-1:0]   r_tag_mem [MAX_OUT];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_issuing, w_full, w_empty, w_push, w_pop, w_last_row;
    logic [AW-1:0]   w_base;
    logic [1:0]      w_type;
    logic [TW-1:0]   w_tag_rd;

    always_comb begin
        w_issuing  = (r_state == S_ISSUE_W) || (r_state == S_ISSUE_IN) || (r_state == S_ISSUE_PS);
        w_full     = (r_count == CW'(MAX_OUT));
        w_empty    = (r_count == '0);
        w_push     = mem.mem_req_valid & mem.mem_req_ready;
        w_pop      = mem.mem_rsp_valid & ~w_empty;
        w_last_row = (r_row == RW'(N - 1));
        w_tag_rd   = r_tag_mem[r_rptr];
        case (r_state)
            S_ISSUE_W:  begin w_base = r_w_base;  w_type = TY_W;  end
            S_ISSUE_PS: begin w_base = r_ps_base; w_type = TY_PS; end
            default:    begin w_base = r_in_base; w_type = TY_IN; end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (req_valid) w_next = req_load_w ? S_WAIT_W : S_WAIT_SPACE;
            S_WAIT_W:     if (w_empty) w_next = S_ISSUE_W;
            S_ISSUE_W:    if (w_push && w_last_row) w_next = S_WAIT_SPACE;
            S_WAIT_SPACE: if (fifo_has_space) w_next = S_ISSUE_IN;
            S_ISSUE_IN:   if (w_push && w_last_row) w_next = S_ISSUE_PS;
            S_ISSUE_PS:   if (w_push && w_last_row) w_next = S_DRAIN;
            S_DRAIN:      if (w_empty) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // Address depends only on registered state, so it holds until the request is taken.
    always_comb begin
        req_ready         = (r_state == S_IDLE);
        mem.mem_req_valid = w_issuing & ~w_full;
        mem.mem_req_addr  = w_base + (AW'(r_row) * AW'(ROW_STRIDE));
        busy              = (r_state != S_IDLE) | ~w_empty;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_load_w  <= 1'b0;
            r_w_base  <= '0;
            r_in_base <= '0;
            r_ps_base <= '0;
            r_row     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            for (int i = 0; i < MAX_OUT; i++) r_tag_mem[i] <= '0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_load_w  <= req_load_w;
                r_w_base  <= req_w_addr;
                r_in_base <= req_in_addr;
                r_ps_base <= req_ps_addr;
                r_row     <= '0;
            end
            if (w_push) begin
                r_row              <= w_last_row ? '0 : r_row + RW'(1);
                r_tag_mem[r_wptr]  <= {w_type, r_row};
                r_wptr             <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            weight_en  <= 1'b0;
            input_en   <= 1'b0;
            partial_en <= 1'b0;
            row_in_en  <= '0;
            row_ps_en  <= '0;
            row_data   <= '0;
            err_rsp    <= 1'b0;
        end else begin
            weight_en  <= 1'b0;
            input_en   <= 1'b0;
            partial_en <= 1'b0;
            row_in_en  <= '0;
            row_ps_en  <= '0;
            if (w_pop) begin
                row_data <= mem.mem_rsp_data;
                case (w_tag_rd[TW-1 -: 2])
                    TY_W:    begin weight_en  <= 1'b1; row_in_en <= w_tag_rd[RW-1:0]; end
                    TY_IN:   begin input_en   <= 1'b1; row_in_en <= w_tag_rd[RW-1:0]; end
                    default: begin partial_en <= 1'b1; row_ps_en <= w_tag_rd[RW-1:0]; end
                endcase
            end
            if (mem.mem_rsp_valid && w_empty) err_rsp <= 1'b1;
        end
    end

`ifdef SYSARR_ROW_LOADER_PERF_EN
    logic w_stall;
    always_comb begin
        w_stall = ((r_state == S_WAIT_SPACE) && !fifo_has_space)
                | (w_issuing && mem.mem_req_valid && !mem.mem_req_ready)
                | (w_issuing && w_full);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)                                 perf_stall_cycles <= '0;
        else if (w_stall && ~&perf_stall_cycles)   perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_sysarr_row_loader.sv
// tb/tb_sysarr_row_loader.sv - randomized bench for sysarr_row_loader with scoreboard memory model
module tb_sysarr_row_loader;
    localparam int N = 4, DW = 16, AW = 32, STRIDE = 64, MAX_OUT = 4;

    logic clk = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0, req_load_w = 1'b0, req_ready;
    logic [AW-1:0]   req_w_addr = '0, req_in_addr = '0, req_ps_addr = '0;
    logic            fifo_has_space = 1'b0;
    logic            weight_en, input_en, partial_en, busy, err_rsp;
    logic [1:0]      row_in_en, row_ps_en;
    logic [N*DW-1:0] row_data;
`ifdef SYSARR_ROW_LOADER_PERF_EN
    logic [31:0]     perf_stall_cycles;
`endif

    sysarr_row_loader_if #(.AW(AW), .N(N), .DW(DW)) mif ();

    sysarr_row_loader #(.N(N), .DW(DW), .AW(AW), .ROW_STRIDE(STRIDE), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_load_w(req_load_w),
        .req_w_addr(req_w_addr), .req_in_addr(req_in_addr), .req_ps_addr(req_ps_addr),
        .mem(mif),
        .fifo_has_space(fifo_has_space),
        .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
        .row_in_en(row_in_en), .row_ps_en(row_ps_en), .row_data(row_data),
        .busy(busy), .err_rsp(err_rsp)
`ifdef SYSARR_ROW_LOADER_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    typedef struct packed {
        logic [1:0]  ty;
        logic [1:0]  row;
        logic [31:0] addr;
    } ent_t;

    ent_t        exp_req[$];
    ent_t        exp_stb[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int lat = 2, rmode = 0, space_cyc = 32'h7fffffff, n_out = 0, n_acc_in = 0, last_stb_cyc = 0;
    bit space_up = 0, cur_lw = 0, in_desc = 0, rst_test = 0;
    bit prev_valid = 0, prev_ready = 0, prev_busy = 0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        mif.mem_req_ready = 1'b0;
        mif.mem_rsp_valid = 1'b0;
        mif.mem_rsp_data  = '0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {a, ~a};
    endfunction

    // Expected rows of one GEMM: weights (optional), then inputs, then partials.
    task automatic model_push(input bit lw, input logic [31:0] w, input logic [31:0] in, input logic [31:0] ps);
        ent_t e;
        for (int m = (lw ? 0 : 1); m < 3; m++) begin
            for (int r = 0; r < N; r++) begin
                e.ty   = 2'(m);
                e.row  = 2'(r);
                e.addr = (m == 0 ? w : m == 1 ? in : ps) + 32'(r * STRIDE);
                exp_req.push_back(e);
                exp_stb.push_back(e);
            end
        end
    endtask

    // Scratchpad model and output monitor, all on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!nRST) begin
                mif.mem_req_ready = 1'b0;
                mif.mem_rsp_valid = 1'b0;
                prev_valid = 0;
                prev_ready = 0;
                prev_busy  = 0;
            end else begin
                int   nstb;
                ent_t e;
                logic [1:0] ty, row;
                nstb = int'(weight_en) + int'(input_en) + int'(partial_en);
                if (nstb > 1) check("one_strobe", 64'(nstb), 64'd1);
                else if (nstb == 1) begin
                    if (exp_stb.size() == 0) check("unexp_strobe", 64'd1, 64'd0);
                    else begin
                        e   = exp_stb.pop_front();
                        ty  = weight_en ? 2'd0 : input_en ? 2'd1 : 2'd2;
                        row = partial_en ? row_ps_en : row_in_en;
                        check("stb_type", 64'(ty), 64'(e.ty));
                        check("stb_row", 64'(row), 64'(e.row));
                        check("stb_data", row_data, mem_data(e.addr));
                        if (partial_en) check("row_in_idle", 64'(row_in_en), 64'd0);
                        else            check("row_ps_idle", 64'(row_ps_en), 64'd0);
                    end
                    last_stb_cyc = cyc;
                end else if (row_in_en != 0 || row_ps_en != 0) begin
                    check("idx_idle", 64'({row_in_en, row_ps_en}), 64'd0);
                end

                if (prev_busy && !busy && !rst_test) check("busy_fall", 64'(cyc), 64'(last_stb_cyc + 1));
                prev_busy = busy;

                if (prev_valid && !prev_ready) begin
                    check("hold_valid", 64'(mif.mem_req_valid), 64'd1);
                    check("hold_addr", 64'(mif.mem_req_addr), 64'(prev_addr));
                end
                if (in_desc && !cur_lw && !space_up) check("no_req_wait", 64'(mif.mem_req_valid), 64'd0);

                mif.mem_req_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));

                if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
                    void'(mem_due_q.pop_front());
                    mif.mem_rsp_valid = 1'b1;
                    mif.mem_rsp_data  = mem_data(mem_addr_q.pop_front());
                    if (n_out > 0) n_out--;
                end else begin
                    mif.mem_rsp_valid = 1'b0;
                    mif.mem_rsp_data  = {$urandom, $urandom};
                end

                if (mif.mem_req_valid && mif.mem_req_ready) begin
                    if (exp_req.size() == 0) check("unexp_req", 64'd1, 64'd0);
                    else begin
                        e = exp_req.pop_front();
                        check("req_addr", 64'(mif.mem_req_addr), 64'(e.addr));
                        if (e.ty == 2'd1) n_acc_in++;
                        if (e.ty != 2'd0) check("space_gate", 64'(cyc > space_cyc), 64'd1);
                    end
                    mem_addr_q.push_back(mif.mem_req_addr);
                    mem_due_q.push_back(cyc + lat);
                    n_out++;
                    check("max_out", 64'(n_out <= MAX_OUT), 64'd1);
                end
                prev_valid = mif.mem_req_valid;
                prev_ready = mif.mem_req_ready;
                prev_addr  = mif.mem_req_addr;
            end
        end
    end

    task automatic run_desc(input bit lw, input logic [31:0] w, input logic [31:0] in, input logic [31:0] ps,
                            input int l, input int rm, input int sd);
        int k;
        @(posedge clk); #2;
        lat = l; rmode = rm; cur_lw = lw;
        space_up = 0; space_cyc = 32'h7fffffff; fifo_has_space = 1'b0;
        req_load_w = lw; req_w_addr = w; req_in_addr = in; req_ps_addr = ps;
        req_valid = 1'b1;
        #2;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        model_push(lw, w, in, ps);
        in_desc = 1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        for (int i = 0; i < sd; i++) begin @(posedge clk); #2; end
        fifo_has_space = 1'b1; space_up = 1; space_cyc = cyc;
        k = 0;
        while (busy && k < 3000) begin
            @(posedge clk); #2;
            fifo_has_space = 1'($urandom_range(0, 1));
            k++;
        end
        check("done_in_time", 64'(k < 3000), 64'd1);
        check("stb_q_empty", 64'(exp_stb.size()), 64'd0);
        check("req_q_empty", 64'(exp_req.size()), 64'd0);
        check("err_clear", 64'(err_rsp), 64'd0);
        check("req_ready_end", 64'(req_ready), 64'd1);
        in_desc = 0;
        fifo_has_space = 1'b0;
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_rsp), 64'd0);
        check("rst_mem_valid", 64'(mif.mem_req_valid), 64'd0);
        check("rst_strobes", 64'({weight_en, input_en, partial_en, row_in_en, row_ps_en}), 64'd0);
        check("rst_row_data", row_data, 64'd0);
        @(posedge clk); #2;
        nRST = 1'b1;

        run_desc(1, 32'h1000, 32'h2000, 32'h3000, 2, 0, 0);
        run_desc(0, 32'h1000, 32'h4000, 32'h5000, 2, 0, 10);
        run_desc(1, 32'h6000, 32'h7000, 32'h8000, 20, 0, 0);
        run_desc(1, 32'h9000, 32'hA000, 32'hB000, 3, 1, 2);
        run_desc(0, 32'h0, 32'hFFFFFFC0, 32'hFFFFFF00, 2, 2, 1);
        for (int t = 0; t < 6; t++)
            run_desc(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                     $urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(0, 12));

        // Reset in the middle of issuing input rows.
        @(posedge clk); #2;
        lat = 20; rmode = 0; cur_lw = 0;
        fifo_has_space = 1'b1; space_up = 1; space_cyc = cyc;
        req_load_w = 1'b0; req_in_addr = 32'h2000; req_ps_addr = 32'h3000;
        req_valid = 1'b1; n_acc_in = 0;
        model_push(0, 32'h0, 32'h2000, 32'h3000);
        in_desc = 1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        k = 0;
        while (n_acc_in < 2 && k < 200) begin @(posedge clk); #2; k++; end
        check("rst_test_reach", 64'(n_acc_in), 64'd2);
        rst_test = 1;
        nRST = 1'b0;
        exp_req.delete();
        exp_stb.delete();
        n_out = 0;
        in_desc = 0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_valid", 64'(mif.mem_req_valid), 64'd0);
        @(posedge clk); #2;
        nRST = 1'b1;
        fifo_has_space = 1'b0;
        check("stale_pending", 64'(mem_due_q.size()), 64'd2);
        k = 0;
        while (mem_due_q.size() > 0 && k < 200) begin @(posedge clk); #2; k++; end
        repeat (3) @(posedge clk);
        #2;
        check("stale_drained", 64'(mem_due_q.size()), 64'd0);
        check("err_rsp_set", 64'(err_rsp), 64'd1);
        check("rst_req_ready_after", 64'(req_ready), 64'd1);
        check("rst_busy_after", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sysarr_row_loader.md
Name: sysarr_row_loader

Overview:
- Memory-side sequencer that feeds one GEMM's operand rows into the systolic array control unit.
- Accepts a GEMM descriptor. Reads weight, input and partial-sum rows from the scratchpad over a pipelined in-order request/response port.
- Drives the array's weight_en / input_en / partial_en and row-index strobes, one row per response.
- Transmit end of the array row-load interface; gated by the array's fifo_has_space.

Parameters:
N, 4, array dimension; rows per operand matrix
DW, 16, element width in bits
AW, 32, scratchpad address width
ROW_STRIDE, 64, byte offset between consecutive rows
MAX_OUT, 4, max outstanding memory requests (power of two, at least 2)

Ports:
clk  in  1  clock
nRST  in  1  async active-low reset
req_valid  in  1  GEMM descriptor valid
req_ready  out  1  descriptor accepted when valid&ready
req_load_w  in  1  descriptor also loads weights
req_w_addr  in  AW  weight base address
req_in_addr  in  AW  input base address
req_ps_addr  in  AW  partial base address
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  scratchpad accepts request
mem_req_addr  out  AW  row address
mem_rsp_valid  in  1  read data valid (in order)
mem_rsp_data  in  N*DW  row data
fifo_has_space  in  1  array can accept a new GEMM's input/partial rows
weight_en  out  1  weight row strobe
input_en  out  1  input row strobe
partial_en  out  1  partial row strobe
row_in_en  out  clog2(N)  row index for weight/input strobe
row_ps_en  out  clog2(N)  row index for partial strobe
row_data  out  N*DW  row payload for the active strobe
busy  out  1  descriptor in progress or requests outstanding
err_rsp  out  1  sticky: response with no outstanding request

Behaviour:
- Reset: nRST is asynchronous, active-low; clock is clk. All outputs 0, req_ready=1, FSM IDLE, tag FIFO empty, counters 0, err_rsp cleared.
- FSM states: IDLE, WAIT_W, ISSUE_W, WAIT_SPACE, ISSUE_IN, ISSUE_PS, DRAIN.
  - IDLE: req_ready=1. On accept, latch the three bases and load_w, then go to WAIT_W if load_w, else WAIT_SPACE.
  - WAIT_W: wait until tag FIFO is empty (previous GEMM's rows delivered), then ISSUE_W.
  - ISSUE_W: issue rows 0..N-1 of weights, then WAIT_SPACE.
  - WAIT_SPACE: move to ISSUE_IN when fifo_has_space=1 is sampled.
  - ISSUE_IN: issue input rows 0..N-1, then ISSUE_PS.
  - ISSUE_PS: issue partial rows 0..N-1, then DRAIN.
  - DRAIN: return to IDLE in the cycle after the tag FIFO is empty.
- Issue rule: mem_req_valid=1 in ISSUE_* when tag FIFO count < MAX_OUT. The request completes on mem_req_valid & mem_req_ready. mem_req_addr = base + row*ROW_STRIDE, truncated to AW (wraps mod 2^AW). mem_req_valid and mem_req_addr hold stable until accepted.
- Tag FIFO: on each accepted request, push {type(2b), row}. On mem_rsp_valid, pop; the tag selects the strobe.
  - type W: weight_en=1, row_in_en=row.
  - type IN: input_en=1, row_in_en=row.
  - type PS: partial_en=1, row_ps_en=row.
  - row_data = mem_rsp_data, registered.
  - Strobes are 1-cycle pulses, asserted the cycle after mem_rsp_valid (latency 1). At most one strobe per cycle.
  - When inactive, row_in_en and row_ps_en are 0.
- Push and pop in the same cycle: count unchanged. Full (count=MAX_OUT): mem_req_valid=0.
- mem_rsp_valid with empty tag FIFO: response dropped, no strobe, err_rsp set (cleared only by reset).
- Input rows are always issued before partial rows, so input row 0 reaches the array before any partial row of the same GEMM.
- fifo_has_space is sampled only in WAIT_SPACE; later deassertion does not stall a GEMM in progress.
- busy = (state != IDLE) | (tag count != 0).
- Reset mid-operation: all state cleared immediately. Responses to requests issued before reset are treated as unexpected and set err_rsp.

Optional Feature:
SYSARR_ROW_LOADER_PERF_EN
- Defined: adds output perf_stall_cycles (32b). It increments each cycle in which any of these holds:
  - state is WAIT_SPACE with fifo_has_space=0;
  - state is ISSUE_* with mem_req_valid=1 and mem_req_ready=0;
  - state is ISSUE_* with the tag FIFO full.
  Saturates at all-ones; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- N=4, load_w=1, weight base 0x1000, mem_req_ready=1, fixed 2-cycle latency, fifo_has_space=1 -> 12 requests at 0x1000,0x1040,0x1080,0x10C0 then input and partial rows. weight_en pulses rows 0-3, then input_en rows 0-3, then partial_en rows 0-3. busy falls 1 cycle after the last strobe; req_ready=1.
- load_w=0, fifo_has_space=0 for 10 cycles, then 1 -> no mem_req_valid during the wait; input requests start the cycle after space is seen; no weight_en at all.
- Memory latency 20, MAX_OUT=4 -> never more than 4 unacknowledged requests; mem_req_valid drops while full; all 8 rows still delivered in order.
- mem_req_ready toggles 1/0 each cycle -> mem_req_addr holds stable while ready=0; no duplicate or skipped row indices.
- Assert nRST mid-ISSUE_IN after 2 input rows, then deliver 2 stale responses -> no strobes, err_rsp=1, req_ready=1, busy=0.
- Input base 0xFFFFFFC0, ROW_STRIDE 64 -> row 1 address wraps to 0x00000000.
